// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared definitions for the Wishbone round-robin arbiter.
//   arb_state_t  - arbiter FSM states (IDLE / BUSY / TOERR)
//   CTI_* / BTE_* - Wishbone B3 cycle-type and burst-type encodings
//   WDOG_W       - width of the watchdog counter
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      TOERR = 2'd2
   } arb_state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   localparam int unsigned WDOG_W = 16;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   - request vector, one bit per master
//   last  - index of the most recently granted master
//   pick  - one-hot winner: first requester searching upward from last+1 with wrap
//   valid - at least one request is present
module rr_pick #(
   parameter int unsigned N  = 2,
   parameter int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last,
   output logic [N-1:0]  pick,
   output logic          valid
);

   always_comb begin : search
      int unsigned idx;
      idx   = 0;
      pick  = '0;
      valid = 1'b0;
      // Offsets 1..N visit every master once, ending on last itself.
      for (int unsigned i = 1; i <= N; i++) begin
         idx = (32'(last) + i) % N;
         if (!valid && req[idx]) begin
            pick[idx] = 1'b1;
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone B3 arbiter sharing one slave port.
//   wb_clk, wb_rst           - clock, asynchronous active-high reset
//   wbm_*_i                  - packed master requests, master k at slice k
//   wbm_dat_o                - slave read data broadcast to all masters
//   wbm_ack/err/rty_o        - responses, routed to the granted master only
//   wbs_*_o / wbs_*_i        - shared slave port
//   grant_o                  - registered one-hot grant
//   timeout_o                - one-cycle pulse when the watchdog fires
// A grant lasts for the owner's whole cyc. A slave that leaves stb
// unanswered for TIMEOUT cycles gets the access terminated with err.
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned AW          = 32,
   parameter int unsigned DW          = 32,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic                          wb_clk,
   input  logic                          wb_rst,
   input  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i,
   input  logic [NUM_MASTERS*(DW/8)-1:0] wbm_sel_i,
   input  logic [NUM_MASTERS*3-1:0]      wbm_cti_i,
   input  logic [NUM_MASTERS*2-1:0]      wbm_bte_i,
   input  logic [NUM_MASTERS-1:0]        wbm_we_i,
   input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
   output logic [DW-1:0]                 wbm_dat_o,
   output logic [NUM_MASTERS-1:0]        wbm_ack_o,
   output logic [NUM_MASTERS-1:0]        wbm_err_o,
   output logic [NUM_MASTERS-1:0]        wbm_rty_o,
   output logic [AW-1:0]                 wbs_adr_o,
   output logic [DW-1:0]                 wbs_dat_o,
   output logic [DW/8-1:0]               wbs_sel_o,
   output logic [2:0]                    wbs_cti_o,
   output logic [1:0]                    wbs_bte_o,
   output logic                          wbs_we_o,
   output logic                          wbs_cyc_o,
   output logic                          wbs_stb_o,
   input  logic [DW-1:0]                 wbs_dat_i,
   input  logic                          wbs_ack_i,
   input  logic                          wbs_err_i,
   input  logic                          wbs_rty_i,
   output logic [NUM_MASTERS-1:0]        grant_o,
   output logic                          timeout_o
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   // Counter value of the last tolerated unanswered cycle; one more fires.
   localparam logic [WDOG_W-1:0] TO_LAST = WDOG_W'(TIMEOUT - 1);

   arb_state_t               state_q, state_d;
   logic [NUM_MASTERS-1:0]   grant_q, grant_d;
   logic [LW-1:0]            last_q, last_d;
   logic [WDOG_W-1:0]        cnt_q, cnt_d;

   logic [NUM_MASTERS-1:0]   pick;
   logic                     pick_valid;
   logic [LW-1:0]            pick_idx;
   logic                     cur_cyc, cur_stb, slv_resp;

   rr_pick #(
      .N  (NUM_MASTERS),
      .LW (LW)
   ) u_pick (
      .req   (wbm_cyc_i),
      .last  (last_q),
      .pick  (pick),
      .valid (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
         if (pick[k]) pick_idx = LW'(k);
      end
   end

   assign cur_cyc  = |(grant_q & wbm_cyc_i);
   assign cur_stb  = |(grant_q & wbm_stb_i);
   assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

   // State register
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LW'(NUM_MASTERS - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, grant and watchdog
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pick_valid) begin
               state_d = BUSY;
               grant_d = pick;
               last_d  = pick_idx;
            end
         end
         BUSY: begin
            if (!cur_cyc) begin
               state_d = IDLE;
               grant_d = '0;
               cnt_d   = '0;
            end else if (!cur_stb || slv_resp) begin
               // A response in the firing cycle wins over the watchdog.
               cnt_d = '0;
            end else if (cnt_q == TO_LAST) begin
               state_d = TOERR;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TOERR: begin
            cnt_d = '0;
            if (cur_cyc) begin
               state_d = BUSY;
            end else begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: grant_q is zero in IDLE, so the AND-OR mux drives zeros there.
   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_cti_o = '0;
      wbs_bte_o = '0;
      wbs_we_o  = 1'b0;
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
         if (grant_q[k]) begin
            wbs_adr_o = wbm_adr_i[k*AW +: AW];
            wbs_dat_o = wbm_dat_i[k*DW +: DW];
            wbs_sel_o = wbm_sel_i[k*SW +: SW];
            wbs_cti_o = wbm_cti_i[k*3 +: 3];
            wbs_bte_o = wbm_bte_i[k*2 +: 2];
            wbs_we_o  = wbm_we_i[k];
         end
      end
      wbs_cyc_o = (state_q == BUSY) && cur_cyc;
      wbs_stb_o = (state_q == BUSY) && cur_stb;
      wbm_ack_o = (state_q == BUSY && wbs_ack_i) ? grant_q : '0;
      wbm_rty_o = (state_q == BUSY && wbs_rty_i) ? grant_q : '0;
      wbm_err_o = ((state_q == BUSY && wbs_err_i) || state_q == TOERR) ? grant_q : '0;
      timeout_o = (state_q == TOERR);
   end

   assign grant_o   = grant_q;
   assign wbm_dat_o = wbs_dat_i;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
   import wb_arb_pkg::*;

   localparam int unsigned N  = 2;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned TO = 8;
   localparam logic [AW-1:0] ADR0 = 32'hA000_0010;
   localparam logic [AW-1:0] ADR1 = 32'hB000_0020;

   logic              wb_clk;
   logic              wb_rst;
   logic [N*AW-1:0]   wbm_adr_i;
   logic [N*DW-1:0]   wbm_dat_i;
   logic [N*SW-1:0]   wbm_sel_i;
   logic [N*3-1:0]    wbm_cti_i;
   logic [N*2-1:0]    wbm_bte_i;
   logic [N-1:0]      wbm_we_i, wbm_cyc_i, wbm_stb_i;
   logic [DW-1:0]     wbm_dat_o;
   logic [N-1:0]      wbm_ack_o, wbm_err_o, wbm_rty_o;
   logic [AW-1:0]     wbs_adr_o;
   logic [DW-1:0]     wbs_dat_o;
   logic [SW-1:0]     wbs_sel_o;
   logic [2:0]        wbs_cti_o;
   logic [1:0]        wbs_bte_o;
   logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
   logic [DW-1:0]     wbs_dat_i;
   logic              wbs_ack_i, wbs_err_i, wbs_rty_i;
   logic [N-1:0]      grant_o;
   logic              timeout_o;

   wb_rr_arbiter #(
      .NUM_MASTERS (N),
      .AW          (AW),
      .DW          (DW),
      .TIMEOUT     (TO)
   ) dut (
      .wb_clk    (wb_clk),
      .wb_rst    (wb_rst),
      .wbm_adr_i (wbm_adr_i),
      .wbm_dat_i (wbm_dat_i),
      .wbm_sel_i (wbm_sel_i),
      .wbm_cti_i (wbm_cti_i),
      .wbm_bte_i (wbm_bte_i),
      .wbm_we_i  (wbm_we_i),
      .wbm_cyc_i (wbm_cyc_i),
      .wbm_stb_i (wbm_stb_i),
      .wbm_dat_o (wbm_dat_o),
      .wbm_ack_o (wbm_ack_o),
      .wbm_err_o (wbm_err_o),
      .wbm_rty_o (wbm_rty_o),
      .wbs_adr_o (wbs_adr_o),
      .wbs_dat_o (wbs_dat_o),
      .wbs_sel_o (wbs_sel_o),
      .wbs_cti_o (wbs_cti_o),
      .wbs_bte_o (wbs_bte_o),
      .wbs_we_o  (wbs_we_o),
      .wbs_cyc_o (wbs_cyc_o),
      .wbs_stb_o (wbs_stb_o),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_i (wbs_ack_i),
      .wbs_err_i (wbs_err_i),
      .wbs_rty_i (wbs_rty_i),
      .grant_o   (grant_o),
      .timeout_o (timeout_o)
   );

   initial wb_clk = 1'b0;
   always #5 wb_clk = ~wb_clk;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // One cycle of stimulus and the outputs expected in that cycle.
   typedef struct packed {
      logic [N-1:0] cyc;
      logic [N-1:0] stb;
      logic         ack;
      logic         err;
      logic [N-1:0] e_grant;
      logic         e_cyc;
      logic         e_stb;
      logic [N-1:0] e_ack;
      logic [N-1:0] e_err;
      logic         e_to;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [N-1:0] cyc, input logic [N-1:0] stb,
                      input logic ack, input logic err,
                      input logic [N-1:0] g, input logic sc, input logic ss,
                      input logic [N-1:0] ea, input logic [N-1:0] ee, input logic to);
      vec_t v;
      v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err;
      v.e_grant = g; v.e_cyc = sc; v.e_stb = ss;
      v.e_ack = ea; v.e_err = ee; v.e_to = to;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      wb_rst    = 1'b1;
      wbm_adr_i = '0;
      wbm_dat_i = '0;
      wbm_sel_i = '0;
      wbm_cti_i = '0;
      wbm_bte_i = '0;
      wbm_we_i  = '0;
      wbm_cyc_i = '0;
      wbm_stb_i = '0;
      wbs_dat_i = '0;
      wbs_ack_i = 1'b0;
      wbs_err_i = 1'b0;
      wbs_rty_i = 1'b0;
      repeat (2) @(posedge wb_clk);
      #1;
      check("rst_grant", 64'(grant_o), 64'(0));
      check("rst_scyc", 64'({wbs_cyc_o, wbs_stb_o}), 64'(0));
      check("rst_timeout", 64'(timeout_o), 64'(0));
      check("rst_resp", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'(0));
      wb_rst = 1'b0;
   endtask

   // Reference model: owner index (-1 = nobody), rotation pointer,
   // error-cycle flag and count of consecutive unanswered strobes.
   int   m_owner;
   int   m_last;
   bit   m_toerr;
   int   m_unans;

   task automatic model_init();
      m_owner = -1;
      m_last  = N - 1;
      m_toerr = 1'b0;
      m_unans = 0;
   endtask

   task automatic model_step();
      logic [N-1:0]  e_g, e_ack, e_err, e_rty;
      logic          e_cyc, e_stb;
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_dat;
      logic [13:0]   e_ctl;
      bit            found;
      int            c;
      e_g = '0; e_ack = '0; e_err = '0; e_rty = '0;
      e_cyc = 1'b0; e_stb = 1'b0;
      e_adr = '0; e_dat = '0; e_ctl = '0;
      if (m_owner >= 0) begin
         e_g[m_owner] = 1'b1;
         e_adr = wbm_adr_i[m_owner*AW +: AW];
         e_dat = wbm_dat_i[m_owner*DW +: DW];
         e_ctl = {wbm_cti_i[m_owner*3 +: 3], wbm_bte_i[m_owner*2 +: 2],
                  wbm_we_i[m_owner], wbm_sel_i[m_owner*SW +: SW]};
         if (m_toerr) begin
            e_err = e_g;
         end else begin
            e_cyc = wbm_cyc_i[m_owner];
            e_stb = wbm_stb_i[m_owner];
            if (wbs_ack_i) e_ack = e_g;
            if (wbs_err_i) e_err = e_g;
            if (wbs_rty_i) e_rty = e_g;
         end
      end
      check("rnd_grant", 64'(grant_o), 64'(e_g));
      check("rnd_cycstb", 64'({wbs_cyc_o, wbs_stb_o}), 64'({e_cyc, e_stb}));
      check("rnd_adr", 64'(wbs_adr_o), 64'(e_adr));
      check("rnd_wdat", 64'(wbs_dat_o), 64'(e_dat));
      check("rnd_ctl", 64'({wbs_cti_o, wbs_bte_o, wbs_we_o, wbs_sel_o}), 64'(e_ctl));
      check("rnd_resp", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'({e_ack, e_err, e_rty}));
      check("rnd_timeout", 64'(timeout_o), 64'(m_toerr));
      check("rnd_rdat", 64'(wbm_dat_o), 64'(wbs_dat_i));
      // advance to the next cycle
      if (m_owner < 0) begin
         found = 1'b0;
         for (int i = 1; i <= N; i++) begin
            c = (m_last + i) % N;
            if (!found && wbm_cyc_i[c]) begin
               found   = 1'b1;
               m_owner = c;
               m_last  = c;
            end
         end
         m_unans = 0;
      end else if (m_toerr) begin
         m_toerr = 1'b0;
         m_unans = 0;
         if (!wbm_cyc_i[m_owner]) m_owner = -1;
      end else if (!wbm_cyc_i[m_owner]) begin
         m_owner = -1;
         m_unans = 0;
      end else if (!wbm_stb_i[m_owner] || wbs_ack_i || wbs_err_i || wbs_rty_i) begin
         m_unans = 0;
      end else if (m_unans + 1 == TO) begin
         m_toerr = 1'b1;
         m_unans = 0;
      end else begin
         m_unans++;
      end
   endtask

   initial begin
      bit          dead;
      int unsigned r;
      logic [2:0]  exp_cti;

      // Single read, alternating owners, slave err routing, watchdog.
      add(2'b01, 2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
      add(2'b01, 2'b01, 0, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0);
      add(2'b01, 2'b01, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 0);
      add(2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0);
      add(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
      add(2'b11, 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
      add(2'b11, 2'b11, 1, 0, 2'b10, 1, 1, 2'b10, 2'b00, 0);
      add(2'b01, 2'b01, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00, 0);
      add(2'b11, 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
      add(2'b11, 2'b11, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 0);
      add(2'b10, 2'b10, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0);
      add(2'b10, 2'b10, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
      add(2'b10, 2'b10, 0, 1, 2'b10, 1, 1, 2'b00, 2'b10, 0);
      add(2'b00, 2'b00, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00, 0);
      add(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
      add(2'b01, 2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);
      for (int i = 0; i < int'(TO); i++)
         add(2'b01, 2'b01, 0, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0);
      add(2'b01, 2'b01, 0, 0, 2'b01, 0, 0, 2'b00, 2'b01, 1);
      for (int i = 0; i < int'(TO) - 1; i++)
         add(2'b01, 2'b01, 0, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0);
      add(2'b01, 2'b01, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 0);
      add(2'b01, 2'b01, 0, 0, 2'b01, 1, 1, 2'b00, 2'b00, 0);
      add(2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0);
      add(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0);

      do_reset();
      wbm_adr_i = {ADR1, ADR0};
      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge wb_clk); #1;
         wbm_cyc_i = tbl[i].cyc;
         wbm_stb_i = tbl[i].stb;
         wbs_ack_i = tbl[i].ack;
         wbs_err_i = tbl[i].err;
         @(negedge wb_clk);
         check($sformatf("tbl%0d_grant", i), 64'(grant_o), 64'(tbl[i].e_grant));
         check($sformatf("tbl%0d_cycstb", i), 64'({wbs_cyc_o, wbs_stb_o}),
               64'({tbl[i].e_cyc, tbl[i].e_stb}));
         check($sformatf("tbl%0d_ack", i), 64'(wbm_ack_o), 64'(tbl[i].e_ack));
         check($sformatf("tbl%0d_err", i), 64'(wbm_err_o), 64'(tbl[i].e_err));
         check($sformatf("tbl%0d_timeout", i), 64'(timeout_o), 64'(tbl[i].e_to));
         check($sformatf("tbl%0d_adr", i), 64'(wbs_adr_o),
               64'(tbl[i].e_grant == 2'b01 ? ADR0 : tbl[i].e_grant == 2'b10 ? ADR1 : '0));
      end

      // 4-beat incrementing burst by m0 while m1 keeps requesting.
      do_reset();
      @(posedge wb_clk); #1;
      wbm_cyc_i = 2'b11;
      wbm_stb_i = 2'b11;
      wbm_cti_i = {CTI_CLASSIC, CTI_INCR};
      @(negedge wb_clk);
      check("burst_idle", 64'(grant_o), 64'(0));
      for (int b = 0; b < 4; b++) begin
         @(posedge wb_clk); #1;
         exp_cti = (b == 3) ? CTI_EOB : CTI_INCR;
         wbm_cti_i[2:0] = exp_cti;
         wbs_ack_i = 1'b1;
         @(negedge wb_clk);
         check($sformatf("burst%0d_grant", b), 64'(grant_o), 64'(2'b01));
         check($sformatf("burst%0d_cti", b), 64'(wbs_cti_o), 64'(exp_cti));
         check($sformatf("burst%0d_ack", b), 64'(wbm_ack_o), 64'(2'b01));
      end
      @(posedge wb_clk); #1;
      wbm_cyc_i[0] = 1'b0;
      wbm_stb_i[0] = 1'b0;
      wbs_ack_i    = 1'b0;
      @(negedge wb_clk);
      check("burst_end_grant", 64'(grant_o), 64'(2'b01));
      check("burst_end_cyc", 64'(wbs_cyc_o), 64'(0));
      @(negedge wb_clk);
      check("burst_gap_grant", 64'(grant_o), 64'(0));
      @(negedge wb_clk);
      check("burst_m1_grant", 64'(grant_o), 64'(2'b10));
      check("burst_m1_cyc", 64'(wbs_cyc_o), 64'(1));

      // Asynchronous reset while m1 is being acked.
      @(posedge wb_clk); #1;
      wbs_ack_i = 1'b1;
      @(negedge wb_clk);
      check("pre_rst_ack", 64'(wbm_ack_o), 64'(2'b10));
      #2;
      wb_rst = 1'b1;
      #1;
      check("arst_cyc", 64'(wbs_cyc_o), 64'(0));
      check("arst_grant", 64'(grant_o), 64'(0));
      check("arst_ack", 64'(wbm_ack_o), 64'(0));
      wbs_ack_i = 1'b0;
      wbm_cyc_i = 2'b11;
      wbm_stb_i = 2'b11;
      @(posedge wb_clk); #1;
      wb_rst = 1'b0;
      @(negedge wb_clk);
      check("post_rst_idle", 64'(grant_o), 64'(0));
      @(negedge wb_clk);
      check("post_rst_m0_first", 64'(grant_o), 64'(2'b01));

      // Randomised traffic against the reference model.
      do_reset();
      model_init();
      dead = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(posedge wb_clk); #1;
         if (n % 16 == 0) dead = ($urandom_range(3) == 0);
         for (int k = 0; k < N; k++) begin
            if (wbm_cyc_i[k]) begin
               if (k == m_owner && $urandom_range(4) == 0) wbm_cyc_i[k] = 1'b0;
            end else if ($urandom_range(2) == 0) begin
               wbm_cyc_i[k] = 1'b1;
            end
            wbm_stb_i[k] = wbm_cyc_i[k] & ($urandom_range(4) != 0);
            wbm_we_i[k]  = 1'($urandom);
            wbm_adr_i[k*AW +: AW] = AW'($urandom);
            wbm_dat_i[k*DW +: DW] = DW'($urandom);
            wbm_sel_i[k*SW +: SW] = SW'($urandom);
            wbm_cti_i[k*3 +: 3]   = 3'($urandom);
            wbm_bte_i[k*2 +: 2]   = 2'($urandom);
         end
         r = $urandom_range(15);
         wbs_ack_i = !dead && (r < 4);
         wbs_err_i = !dead && (r == 4);
         wbs_rty_i = !dead && (r == 5);
         wbs_dat_i = DW'($urandom);
         @(negedge wb_clk);
         model_step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
